// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths, constants and conversion state type for adc_vol_filter
package adc_pkg;
   localparam int DATA_W        = 12;
   localparam int VOL_W         = 13;
   localparam int CH_W          = 5;
   localparam int FULL_SCALE_MV = 5000;
   localparam int ADC_MAX       = 4095;
   localparam int PROD_W        = 25;
   localparam int BCD_DIGITS    = 4;
   localparam int BCD_W         = 4 * BCD_DIGITS;

   typedef enum logic [2:0] {IDLE, MUL, DIV, BCD, DONE} conv_state_t;
endpackage

// File: rtl/adc_vol_filter_if.sv
// rtl/adc_vol_filter_if.sv - ADC response input and filtered voltage output bundle
interface adc_vol_filter_if;
   import adc_pkg::*;

   logic                response_valid;
   logic [CH_W-1:0]     response_channel;
   logic [DATA_W-1:0]   response_data;
   logic [CH_W-1:0]     expected_channel;
   logic [VOL_W-1:0]    vol;
   logic [BCD_W-1:0]    vol_bcd;
   logic                vol_valid;
   logic                conv_busy;

   modport master (
      output response_valid, response_channel, response_data, expected_channel,
      input  vol, vol_bcd, vol_valid, conv_busy
   );

   modport slave (
      input  response_valid, response_channel, response_data, expected_channel,
      output vol, vol_bcd, vol_valid, conv_busy
   );
endinterface

// File: rtl/seq_restoring_div.sv
// rtl/seq_restoring_div.sv - restoring divider, one quotient bit per cycle over PROD_W cycles
module seq_restoring_div
   import adc_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [PROD_W-1:0]  i_dividend,
   input  logic [DATA_W-1:0]  i_divisor,
   output logic               o_done,
   output logic [VOL_W-1:0]   o_quotient
);
   localparam int CNT_W = $clog2(PROD_W + 1);

   logic [PROD_W-1:0] r_quo;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_div;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;
   logic [DATA_W:0]   w_shift;
   logic [DATA_W:0]   w_diff;
   logic              w_ge;

   // Dividend bits leave r_quo at the top while quotient bits enter at the bottom.
   assign w_shift    = {r_rem, r_quo[PROD_W-1]};
   assign w_diff     = w_shift - {1'b0, r_div};
   assign w_ge       = (w_shift >= {1'b0, r_div});
   assign o_done     = r_busy && (r_cnt == CNT_W'(1));
   assign o_quotient = r_quo[VOL_W-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_quo  <= '0;
         r_rem  <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_quo  <= i_dividend;
         r_rem  <= '0;
         r_div  <= i_divisor;
         r_cnt  <= CNT_W'(PROD_W);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_quo <= {r_quo[PROD_W-2:0], w_ge};
         r_rem <= DATA_W'(w_ge ? w_diff : w_shift);
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
      end
   end
endmodule

// File: rtl/adc_vol_filter.sv
// rtl/adc_vol_filter.sv - channel-gated moving average, millivolt conversion and BCD digits
module adc_vol_filter
   import adc_pkg::*;
#(
   parameter int AVG_LOG2 = 3
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   adc_vol_filter_if.slave io_bus
);
   localparam int N      = 1 << AVG_LOG2;
   localparam int SUM_W  = DATA_W + AVG_LOG2;
   localparam int FILL_W = AVG_LOG2 + 1;
   localparam int BIT_W  = $clog2(VOL_W);

   logic [CH_W-1:0]     r_exp_ch;
   logic [DATA_W-1:0]   r_buf [N];
   logic [AVG_LOG2-1:0] r_wptr;
   logic [FILL_W-1:0]   r_fill;
   logic [SUM_W-1:0]    r_sum;
   logic                r_pending;
   conv_state_t         r_state;
   conv_state_t         w_next;
   logic [DATA_W-1:0]   r_avg;
   logic [BCD_W-1:0]    r_bcd;
   logic [BCD_W-1:0]    w_bcd_adj;
   logic [BIT_W-1:0]    r_bit;
   logic [VOL_W-1:0]    r_vol;
   logic [BCD_W-1:0]    r_vol_bcd;
   logic                r_vol_valid;
   logic [VOL_W-1:0]    w_quo;
   logic [PROD_W-1:0]   w_product;
   logic                w_accept;
   logic                w_ch_change;
   logic                w_fill_done;
   logic                w_take;
   logic                w_div_start;
   logic                w_div_done;

   assign w_accept    = io_bus.response_valid && (io_bus.response_channel == io_bus.expected_channel);
   assign w_ch_change = (io_bus.expected_channel != r_exp_ch);
   // After a flush the window holds one sample, so only an unflushed accept can complete it.
   assign w_fill_done = w_accept && !w_ch_change && (r_fill >= FILL_W'(N - 1));
   assign w_take      = (r_state == IDLE) && r_pending;
   assign w_product   = PROD_W'(r_avg) * PROD_W'(FULL_SCALE_MV);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_exp_ch  <= '0;
         r_wptr    <= '0;
         r_fill    <= '0;
         r_sum     <= '0;
         r_pending <= 1'b0;
         for (int i = 0; i < N; i++) r_buf[i] <= '0;
      end else begin
         r_exp_ch <= io_bus.expected_channel;
         if (w_ch_change) begin
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
            r_wptr <= '0;
            r_fill <= '0;
            r_sum  <= '0;
            if (w_accept) begin
               r_buf[0] <= io_bus.response_data;
               r_wptr   <= AVG_LOG2'(1);
               r_fill   <= FILL_W'(1);
               r_sum    <= SUM_W'(io_bus.response_data);
            end
         end else if (w_accept) begin
            r_buf[r_wptr] <= io_bus.response_data;
            r_wptr        <= r_wptr + AVG_LOG2'(1);
            if (r_fill != FILL_W'(N)) r_fill <= r_fill + FILL_W'(1);
            r_sum <= r_sum + SUM_W'(io_bus.response_data) - SUM_W'(r_buf[r_wptr]);
         end
         if (w_fill_done) r_pending <= 1'b1;
         else if (w_ch_change || w_take) r_pending <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_div_start = 1'b0;
      case (r_state)
         IDLE: if (r_pending) w_next = MUL;
         MUL: begin
            w_div_start = 1'b1;
            w_next      = DIV;
         end
         DIV:  if (w_div_done) w_next = BCD;
         BCD:  if (r_bit == BIT_W'(VOL_W - 1)) w_next = DONE;
         DONE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
   end

   // Double-dabble walks the held quotient MSB first, one bit per BCD cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_avg       <= '0;
         r_bcd       <= '0;
         r_bit       <= '0;
         r_vol       <= '0;
         r_vol_bcd   <= '0;
         r_vol_valid <= 1'b0;
      end else begin
         r_vol_valid <= 1'b0;
         if (w_take) r_avg <= r_sum[SUM_W-1:AVG_LOG2];
         if ((r_state == DIV) && w_div_done) begin
            r_bcd <= '0;
            r_bit <= '0;
         end
         if (r_state == BCD) begin
            r_bcd <= BCD_W'({w_bcd_adj, w_quo[BIT_W'(VOL_W - 1) - r_bit]});
            r_bit <= r_bit + BIT_W'(1);
         end
         if (r_state == DONE) begin
            r_vol       <= w_quo;
            r_vol_bcd   <= r_bcd;
            r_vol_valid <= 1'b1;
         end
      end
   end

   seq_restoring_div u_div (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (w_div_start),
      .i_dividend (w_product),
      .i_divisor  (DATA_W'(ADC_MAX)),
      .o_done     (w_div_done),
      .o_quotient (w_quo)
   );

   assign io_bus.vol       = r_vol;
   assign io_bus.vol_bcd   = r_vol_bcd;
   assign io_bus.vol_valid = r_vol_valid;
   assign io_bus.conv_busy = (r_state != IDLE);
endmodule

// File: tb/tb_adc_vol_filter.sv
// tb/tb_adc_vol_filter.sv - directed vector bench for adc_vol_filter
module tb_adc_vol_filter;
   import adc_pkg::*;

   typedef struct {
      bit          rst;
      logic [4:0]  exp_ch;
      logic [4:0]  ch;
      logic [11:0] data;
      int          n;
      int          pulses;
      logic [12:0] vol;
      logic [15:0] bcd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adc_vol_filter_if bus();

   adc_vol_filter #(.AVG_LOG2(3)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [VOL_W-1:0] q_vol [$];
   logic [BCD_W-1:0] q_bcd [$];
   int               q_cyc [$];
   always @(negedge clk) begin
      if (rst_n && bus.vol_valid) begin
         q_vol.push_back(bus.vol);
         q_bcd.push_back(bus.vol_bcd);
         q_cyc.push_back(cyc);
      end
   end

   int   checks = 0;
   int   errors = 0;
   int   last_acc = 0;
   int   base;
   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic send(input logic [11:0] d, input logic [4:0] ch);
      @(negedge clk);
      bus.response_valid   = 1'b1;
      bus.response_channel = ch;
      bus.response_data    = d;
      last_acc = cyc + 1;
      @(negedge clk);
      bus.response_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_channel(input logic [4:0] ch);
      @(negedge clk);
      bus.expected_channel = ch;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_outputs(input string tag, input int pulses, input logic [12:0] v, input logic [15:0] b);
      check({tag, " pulses"}, q_vol.size() - base, pulses);
      check({tag, " vol"}, bus.vol, v);
      check({tag, " vol_bcd"}, bus.vol_bcd, b);
      check({tag, " conv_busy"}, bus.conv_busy, 0);
      if (pulses == 1 && q_vol.size() == base + 1)
         check({tag, " latency"}, q_cyc[base] - last_acc, 41);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.response_valid   = 1'b0;
      bus.response_channel = '0;
      bus.response_data    = '0;
      bus.expected_channel = 5'd1;
      repeat (3) @(negedge clk);
      check("reset vol", bus.vol, 0);
      check("reset vol_bcd", bus.vol_bcd, 0);
      check("reset vol_valid", bus.vol_valid, 0);
      check("reset conv_busy", bus.conv_busy, 0);
      rst_n = 1'b1;

      tbl[0]  = '{1'b1, 5'd1, 5'd2, 12'd4095, 8, 0, 13'd0,    16'h0000};
      tbl[1]  = '{1'b0, 5'd1, 5'd1, 12'd4095, 8, 1, 13'd5000, 16'h5000};
      tbl[2]  = '{1'b1, 5'd1, 5'd1, 12'd2048, 8, 1, 13'd2500, 16'h2500};
      tbl[3]  = '{1'b0, 5'd1, 5'd1, 12'd0,    1, 1, 13'd2188, 16'h2188};
      tbl[4]  = '{1'b0, 5'd3, 5'd3, 12'd1000, 7, 0, 13'd2188, 16'h2188};
      tbl[5]  = '{1'b0, 5'd3, 5'd3, 12'd1000, 1, 1, 13'd1221, 16'h1221};
      tbl[6]  = '{1'b1, 5'd5, 5'd5, 12'd4094, 8, 1, 13'd4998, 16'h4998};
      tbl[7]  = '{1'b1, 5'd1, 5'd1, 12'd1,    8, 1, 13'd1,    16'h0001};
      tbl[8]  = '{1'b1, 5'd1, 5'd1, 12'd7,    8, 1, 13'd8,    16'h0008};
      tbl[9]  = '{1'b1, 5'd1, 5'd1, 12'd819,  8, 1, 13'd1000, 16'h1000};
      tbl[10] = '{1'b1, 5'd2, 5'd2, 12'd3000, 8, 1, 13'd3663, 16'h3663};

      for (int r = 0; r < 11; r++) begin
         if (tbl[r].rst) do_reset();
         set_channel(tbl[r].exp_ch);
         base = q_vol.size();
         for (int i = 0; i < tbl[r].n; i++) send(tbl[r].data, tbl[r].ch);
         repeat (60) @(negedge clk);
         check_outputs($sformatf("row%0d", r), tbl[r].pulses, tbl[r].vol, tbl[r].bcd);
      end

      // Accepts during a conversion coalesce into one follow-up of the newest average.
      do_reset();
      set_channel(5'd1);
      base = q_vol.size();
      for (int i = 0; i < 8; i++) send(12'd2048, 5'd1);
      for (int i = 0; i < 5; i++) send(12'd4095, 5'd1);
      repeat (110) @(negedge clk);
      check("coalesce pulses", q_vol.size() - base, 2);
      if (q_vol.size() >= base + 2) begin
         check("coalesce first vol", q_vol[base], 2500);
         check("coalesce second vol", q_vol[base+1], 4062);
         check("coalesce second bcd", q_bcd[base+1], 16'h4062);
      end
      check("coalesce busy", bus.conv_busy, 0);

      // Reset asserted ten cycles into the divide.
      set_channel(5'd2);
      base = q_vol.size();
      for (int i = 0; i < 8; i++) send(12'd4095, 5'd2);
      for (int k = 0; k < 100 && cyc < last_acc + 12; k++) @(negedge clk);
      check("middiv busy", bus.conv_busy, 1);
      check("middiv vol held", bus.vol, 4062);
      #1 rst_n = 1'b0;
      #1;
      check("async reset vol", bus.vol, 0);
      check("async reset vol_bcd", bus.vol_bcd, 0);
      check("async reset busy", bus.conv_busy, 0);
      check("async reset valid", bus.vol_valid, 0);
      check("async reset pulses", q_vol.size() - base, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_channel(5'd1);
      base = q_vol.size();
      for (int i = 0; i < 8; i++) send(12'd4095, 5'd1);
      repeat (60) @(negedge clk);
      check_outputs("post reset", 1, 13'd5000, 16'h5000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
